// File: rtl/pong_game_core.sv
// rtl/pong_game_core.sv - pong match core: paddles, ball, scores, match FSM, pixel colour; PONG_SPEEDUP_EN adds paddle-hit speedup
module pong_game_core #(
   parameter int SCREEN_W    = 780,
   parameter int SCREEN_H    = 480,
   parameter int BORDER      = 5,
   parameter int PADDLE_W    = 11,
   parameter int PADDLE_H    = 76,
   parameter int PA_X        = 10,
   parameter int PB_X        = 760,
   parameter int BALL_SIZE   = 16,
   parameter int POS_SHIFT   = 4,
   parameter int MOVE_DIV    = 91072,
   parameter int SERVE_DELAY = 67108864,
   parameter int WIN_SCORE   = 9
) (
   input  logic        VGA_CLOCK,
   input  logic        RESET_N,
   input  logic [7:0]  PADDLE_A_POSITION,
   input  logic [7:0]  PADDLE_B_POSITION,
   input  logic        START,
   input  logic [10:0] PIXEL_H,
   input  logic [10:0] PIXEL_V,
   output logic [2:0]  PIXEL,
   output logic [10:0] BALL_H,
   output logic [10:0] BALL_V,
   output logic [3:0]  SCORE_A,
   output logic [3:0]  SCORE_B,
   output logic [1:0]  STATE,
   output logic        WINNER
);
   localparam int SD_W  = $clog2(SERVE_DELAY + 1);
   localparam int MD_W  = $clog2(MOVE_DIV + 1);
   localparam int RAW_W = 8 + POS_SHIFT;

   localparam logic [10:0] BRD    = 11'(BORDER);
   localparam logic [10:0] RIGHT  = 11'(SCREEN_W - BORDER);
   localparam logic [10:0] BOTTOM = 11'(SCREEN_H - BORDER);
   localparam logic [10:0] BS     = 11'(BALL_SIZE);
   localparam logic [10:0] PH     = 11'(PADDLE_H);
   localparam logic [10:0] PA_L   = 11'(PA_X);
   localparam logic [10:0] PA_R   = 11'(PA_X + PADDLE_W);
   localparam logic [10:0] PB_L   = 11'(PB_X);
   localparam logic [10:0] PB_R   = 11'(PB_X + PADDLE_W);
   localparam logic [10:0] CX     = 11'(SCREEN_W / 2 - BALL_SIZE / 2);
   localparam logic [10:0] CY     = 11'(SCREEN_H / 2 - BALL_SIZE / 2);
   localparam logic [10:0] NET_L  = 11'(SCREEN_W / 2 - 1);
   localparam logic [10:0] NET_R  = 11'(SCREEN_W / 2);
   localparam logic [RAW_W-1:0] PAD_MAX = RAW_W'(SCREEN_H - BORDER - PADDLE_H);
   localparam logic [MD_W-1:0]  MD      = MD_W'(MOVE_DIV);
   localparam logic [SD_W-1:0]  SD_LAST = SD_W'(SERVE_DELAY - 1);
   localparam logic [3:0]       WS      = 4'(WIN_SCORE);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SERVE = 2'd1, S_PLAY = 2'd2, S_OVER = 2'd3} state_t;

   state_t            state, state_nx;
   logic [10:0]       pa_pos, pb_pos, ball_h, ball_v, h_nx, v_nx;
   logic [RAW_W-1:0]  pa_raw, pb_raw;
   logic              dir_h, dir_v, dh_nx, dv_nx, winner;
   logic [3:0]        score_a, score_b;
   logic [SD_W-1:0]   serve_cnt;
   logic [MD_W-1:0]   tick_cnt, period;
   logic              tick, miss_r, point_a, point_b, win_a, win_b, hit_a, hit_b, start_match;
   logic              on_pad, on_border, on_ball, on_net;

   assign pa_raw = RAW_W'(PADDLE_A_POSITION) << POS_SHIFT;
   assign pb_raw = RAW_W'(PADDLE_B_POSITION) << POS_SHIFT;

   assign start_match = ((state == S_IDLE) || (state == S_OVER)) && START;
   assign tick        = (state == S_PLAY) && (tick_cnt == period - 1'b1);
   assign miss_r      = (ball_h + BS >= RIGHT);
   assign point_a     = tick && miss_r;
   assign point_b     = tick && !miss_r && (ball_h <= BRD);
   assign win_a       = point_a && (score_a == WS - 4'd1);
   assign win_b       = point_b && (score_b == WS - 4'd1);
   assign hit_b       = dir_h && (ball_h + BS == PB_L) &&
                        (ball_v + BS > pb_pos) && (ball_v < pb_pos + PH);
   assign hit_a       = !dir_h && (ball_h == PA_R) &&
                        (ball_v + BS > pa_pos) && (ball_v < pa_pos + PH);

   // paddle registers: scaled input clamped so the paddle never enters the bottom border
   always_ff @(posedge VGA_CLOCK) begin
      if (!RESET_N) begin
         pa_pos <= '0;
         pb_pos <= '0;
      end else begin
         pa_pos <= (pa_raw > PAD_MAX) ? 11'(PAD_MAX) : 11'(pa_raw);
         pb_pos <= (pb_raw > PAD_MAX) ? 11'(PAD_MAX) : 11'(pb_raw);
      end
   end

   // match state register
   always_ff @(posedge VGA_CLOCK) begin
      if (!RESET_N) state <= S_IDLE;
      else          state <= state_nx;
   end

   // match transitions: start, serve delay expiry, points and match end
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_OVER: if (START) state_nx = S_SERVE;
         S_SERVE:        if (serve_cnt == SD_LAST) state_nx = S_PLAY;
         S_PLAY: begin
            if (win_a || win_b)          state_nx = S_OVER;
            else if (point_a || point_b) state_nx = S_SERVE;
         end
         default:        state_nx = S_IDLE;
      endcase
   end

   // serve delay and move tick counters; both restart whenever their state is (re)entered
   always_ff @(posedge VGA_CLOCK) begin
      if (!RESET_N) begin
         serve_cnt <= '0;
         tick_cnt  <= '0;
      end else begin
         serve_cnt <= (state == S_SERVE && state_nx == S_SERVE) ? serve_cnt + 1'b1 : '0;
         tick_cnt  <= (state == S_PLAY && !tick) ? tick_cnt + 1'b1 : '0;
      end
   end

`ifdef PONG_SPEEDUP_EN
   localparam logic [MD_W-1:0] STEP  = MD_W'(MOVE_DIV >> 3);
   localparam logic [MD_W-1:0] FLOOR = MD_W'(MOVE_DIV / 2);
   // tick period shrinks on each paddle hit down to a floor, back to full length during serve
   always_ff @(posedge VGA_CLOCK) begin
      if (!RESET_N || state == S_SERVE) period <= MD;
      else if (tick && (hit_a || hit_b))
         period <= (period - STEP < FLOOR) ? FLOOR : period - STEP;
   end
`else
   assign period = MD;
`endif

   // next ball step: wall bounce and paddle bounce may both apply on one tick
   always_comb begin
      dv_nx = dir_v;
      if (!dir_v && ball_v == BRD)          dv_nx = 1'b1;
      else if (dir_v && ball_v + BS == BOTTOM) dv_nx = 1'b0;
      dh_nx = dir_h;
      if (hit_b)      dh_nx = 1'b0;
      else if (hit_a) dh_nx = 1'b1;
      v_nx = dv_nx ? ball_v + 11'd1 : ball_v - 11'd1;
      h_nx = dh_nx ? ball_h + 11'd1 : ball_h - 11'd1;
   end

   // ball, direction, score and winner registers
   always_ff @(posedge VGA_CLOCK) begin
      if (!RESET_N) begin
         ball_h  <= CX;
         ball_v  <= CY;
         dir_h   <= 1'b1;
         dir_v   <= 1'b1;
         score_a <= '0;
         score_b <= '0;
         winner  <= 1'b0;
      end else if (start_match) begin
         ball_h  <= CX;
         ball_v  <= CY;
         dir_h   <= 1'b1;
         score_a <= '0;
         score_b <= '0;
      end else if (point_a || point_b) begin
         ball_h <= CX;
         ball_v <= CY;
         // the next serve travels away from the side that just missed
         dir_h  <= point_b;
         if (point_a && score_a != WS) score_a <= score_a + 4'd1;
         if (point_b && score_b != WS) score_b <= score_b + 4'd1;
         if (win_a || win_b) winner <= win_b;
      end else if (tick) begin
         ball_h <= h_nx;
         ball_v <= v_nx;
         dir_h  <= dh_nx;
         dir_v  <= dv_nx;
      end
   end

   assign on_pad    = ((PIXEL_H >= PA_L) && (PIXEL_H < PA_R) && (PIXEL_V >= pa_pos) && (PIXEL_V < pa_pos + PH)) ||
                      ((PIXEL_H >= PB_L) && (PIXEL_H < PB_R) && (PIXEL_V >= pb_pos) && (PIXEL_V < pb_pos + PH));
   assign on_border = (PIXEL_H < BRD) || (PIXEL_H >= RIGHT) || (PIXEL_V < BRD) || (PIXEL_V >= BOTTOM);
   assign on_ball   = (state == S_PLAY) && (PIXEL_H >= ball_h) && (PIXEL_H < ball_h + BS) &&
                      (PIXEL_V >= ball_v) && (PIXEL_V < ball_v + BS);
   assign on_net    = ((PIXEL_H == NET_L) || (PIXEL_H == NET_R)) && PIXEL_V[4];

   // registered pixel colour in priority order paddle, border, ball, net
   always_ff @(posedge VGA_CLOCK) begin
      if (!RESET_N)       PIXEL <= 3'b000;
      else if (on_pad)    PIXEL <= 3'b111;
      else if (on_border) PIXEL <= 3'b100;
      else if (on_ball)   PIXEL <= 3'b001;
      else if (on_net)    PIXEL <= 3'b110;
      else                PIXEL <= 3'b000;
   end

   assign BALL_H  = ball_h;
   assign BALL_V  = ball_v;
   assign SCORE_A = score_a;
   assign SCORE_B = score_b;
   assign STATE   = state;
   assign WINNER  = winner;
endmodule
